// File: rtl/prime_range_scanner.sv
// Sweeps candidates lo..hi into a combinational prime detector and queues
// every prime into a first-word fall-through FIFO with a valid/ready output.
module prime_range_scanner #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] cand,
  input  logic             is_prime,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cand_n, hi_r, hi_n, count_n;
  logic             done_n;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop, can_accept, advance;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && out_ready;
  assign can_accept = !full || pop;
  assign advance    = !is_prime || can_accept;
  assign push       = (state == SCAN) && advance && is_prime;

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_n = state;
    cand_n  = cand;
    hi_n    = hi_r;
    count_n = prime_count;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          count_n = '0;
          if (lo <= hi) begin
            cand_n  = lo;
            hi_n    = hi;
            state_n = SCAN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (advance) begin
          if (is_prime) count_n = prime_count + WIDTH'(1);
          // Compare before incrementing so hi = all-ones never wraps cand.
          if (cand == hi_r) state_n = FLUSH;
          else              cand_n  = cand + WIDTH'(1);
        end
      end
      FLUSH: begin
        if (empty) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      hi_r        <= '0;
      prime_count <= '0;
      done        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      hi_r        <= hi_n;
      prime_count <= count_n;
      done        <= done_n;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; out_valid gates it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cand;
  end

endmodule

// File: tb/tb_prime_range_scanner.sv
// Drives sweeps into prime_range_scanner with a behavioural prime detector and
// compares the output stream, counts and handshakes against a list-based model.
module tb_prime_range_scanner;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, start, is_prime, out_valid, out_ready, busy, done;
  logic [W-1:0] lo, hi, cand, out_data, prime_count;

  int vectors     = 0;
  int miscompares = 0;
  bit prime_tbl [256];

  always #5 clk = ~clk;

  assign is_prime = prime_tbl[cand];

  prime_range_scanner #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .cand(cand),
    .is_prime(is_prime), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .prime_count(prime_count)
  );

  function automatic bit isp(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full sweep: model list of primes in [l,h], consumer records pops.
  // hold: out_ready forced low for that many cycles, with a stall check at its end.
  // inject: cycle at which a stray start (lo=100, hi=110) is pulsed.
  task automatic run_sweep(input int l, input int h, input bit rnd,
                           input int hold, input int inject, input string tag);
    int q_exp[$];
    int got[$];
    int dones = 0, first_done = -1, bad = 0, k = 0, n_cmp;
    for (int n = l; n <= h; n++) if (isp(n)) q_exp.push_back(n);
    @(negedge clk);
    start = 1'b1; lo = W'(l); hi = W'(h);
    while (first_done < 0 && k < 2000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (inject > 0 && k == inject) begin
        start = 1'b1; lo = 8'd100; hi = 8'd110;
      end
      out_ready = (k <= hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (k == 1 && l <= h) check({tag, "_first_cand"}, 32'(cand), 32'(l));
      if (hold > 0 && k == hold && q_exp.size() > D) begin
        check({tag, "_stall_cand"}, 32'(cand), 32'(q_exp[D]));
        check({tag, "_stall_count"}, 32'(prime_count), 32'(D));
        check({tag, "_stall_head"}, 32'(out_data), 32'(q_exp[0]));
      end
      if (busy && (int'(cand) < l || int'(cand) > h)) bad++;
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (done) begin
        dones++;
        first_done = k;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      if (done) dones++;
      if (out_valid) got.push_back(int'(out_data));
    end
    check({tag, "_finished"}, 32'(first_done > 0), 32'd1);
    if (l > h) check({tag, "_empty_done_latency"}, 32'(first_done), 32'd1);
    check({tag, "_done_pulses"}, 32'(dones), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_prime_count"}, 32'(prime_count), 32'(q_exp.size()));
    check({tag, "_stream_len"}, 32'(got.size()), 32'(q_exp.size()));
    check({tag, "_cand_range"}, 32'(bad), 32'd0);
    n_cmp = (got.size() < q_exp.size()) ? got.size() : q_exp.size();
    for (int i = 0; i < n_cmp; i++)
      check($sformatf("%s_data%0d", tag, i), 32'(got[i]), 32'(q_exp[i]));
  endtask

  initial begin
    int l, h;
    for (int n = 0; n < 256; n++) prime_tbl[n] = isp(n);
    rst = 1'b1; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b0;
    #12;
    check("rst_cand", 32'(cand), 32'd0);
    check("rst_count", 32'(prime_count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 10, 1'b0, 0, 0, "basic");
    run_sweep(13, 13, 1'b0, 0, 0, "single");
    run_sweep(20, 10, 1'b0, 0, 0, "empty_range");
    run_sweep(250, 255, 1'b0, 0, 0, "top_edge");
    run_sweep(2, 20, 1'b0, 30, 0, "backpressure");
    run_sweep(0, 50, 1'b0, 0, 5, "ignored_start");

    // Reset mid-sweep with two primes queued (0 and 1 are not primes).
    @(negedge clk);
    start = 1'b1; lo = 8'd0; hi = 8'd50; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_count", 32'(prime_count), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cand", 32'(cand), 32'd0);
    check("mid_rst_count", 32'(prime_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(2, 5, 1'b0, 0, 0, "after_rst");

    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(0, 255);
      if (i % 3 == 0) h = $urandom_range(0, 255);
      else            h = (l + $urandom_range(0, 40) > 255) ? 255 : l + $urandom_range(0, 40);
      run_sweep(l, h, 1'b1, 0, 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
